dict_update_arbiter: RTL and testbench

DICT_UPDATE_ARBITER -- requirements
Module: dict_update_arbiter

---
 rtl/dict_pkg.sv | 11 +
 rtl/dict_update_queue.sv | 60 ++++++
 rtl/dict_update_arbiter.sv | 113 +++++++++++
 tb/tb_dict_update_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_pkg.sv
// Shared constants and types for the dictionary-update arbiter.
package dict_pkg;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned LANES      = 4;
  localparam int unsigned QDEPTH     = 8;

  typedef enum logic {
    BANK1 = 1'b0,
    BANK2 = 1'b1
  } bank_e;
endpackage

// File: rtl/dict_update_queue.sv
// Circular pending-update buffer: up to LANES compacted writes and 2 head reads per cycle.
module dict_update_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned QDEPTH     = 8,
  localparam int unsigned AW        = $clog2(QDEPTH),
  localparam int unsigned CW        = AW + 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_flush,
  input  logic [CW-1:0]               i_enq_cnt,
  input  logic [LANES*DATA_WIDTH-1:0] i_enq_data,
  input  logic [1:0]                  i_deq_cnt,
  output logic [DATA_WIDTH-1:0]       o_head_data,
  output logic [DATA_WIDTH-1:0]       o_next_data,
  output logic [CW-1:0]               o_count
);

  logic [DATA_WIDTH-1:0] mem_q [QDEPTH];
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    head_d  = head_q + AW'(i_deq_cnt);
    tail_d  = tail_q + i_enq_cnt[AW-1:0];
    count_d = count_q + i_enq_cnt - CW'(i_deq_cnt);
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; it is only observable while count is non-zero.
  always_ff @(posedge i_clk) begin
    for (int unsigned k = 0; k < LANES; k++) begin
      if (!i_flush && (CW'(k) < i_enq_cnt))
        mem_q[tail_q + AW'(k)] <= i_enq_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_head_data = mem_q[head_q];
  assign o_next_data = mem_q[head_q + AW'(1)];
  assign o_count     = count_q;

endmodule

// File: rtl/dict_update_arbiter.sv
// Compacts per-lane dictionary updates into a queue and issues them in strict bank-1/bank-2 alternation.
module dict_update_arbiter #(
  parameter int unsigned DATA_WIDTH = dict_pkg::DATA_WIDTH,
  parameter int unsigned LANES      = dict_pkg::LANES,
  parameter int unsigned QDEPTH     = dict_pkg::QDEPTH
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [LANES-1:0]            i_valid,
  input  logic [LANES*DATA_WIDTH-1:0] i_data,
  output logic                        o_ready,
  input  logic                        i_hold,
  input  logic                        i_flush,
  output logic                        o_wr,
  output logic [DATA_WIDTH-1:0]       o_w_data,
  output logic                        o_wr2,
  output logic [DATA_WIDTH-1:0]       o_w_data2,
  output logic [$clog2(QDEPTH):0]     o_count,
  output logic                        o_busy
);
  import dict_pkg::*;

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  logic [CW-1:0]               count;
  logic [CW-1:0]               valid_cnt;
  logic [CW-1:0]               enq_cnt;
  logic [LANES*DATA_WIDTH-1:0] comp_data;
  logic [1:0]                  n_issue;
  logic [DATA_WIDTH-1:0]       head_data, next_data;
  bank_e                       bank_sel_q, bank_sel_d;

  // Valid lane k lands in slot (number of valid lanes below k).
  always_comb begin
    valid_cnt = '0;
    comp_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (i_valid[k]) begin
        for (int unsigned j = 0; j < LANES; j++) begin
          if (CW'(j) == valid_cnt)
            comp_data[j*DATA_WIDTH +: DATA_WIDTH] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        valid_cnt = valid_cnt + CW'(1);
      end
    end
  end

  assign o_ready = !i_flush && ((CW'(QDEPTH) - count) >= CW'(LANES));
  assign enq_cnt = (o_ready && (|i_valid)) ? valid_cnt : '0;

  always_comb begin
    n_issue = 2'd2;
    if (i_hold || i_flush || (count == '0))
      n_issue = 2'd0;
    else if (count == CW'(1))
      n_issue = 2'd1;
  end

  dict_update_queue #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES),
    .QDEPTH    (QDEPTH)
  ) u_queue (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_flush    (i_flush),
    .i_enq_cnt  (enq_cnt),
    .i_enq_data (comp_data),
    .i_deq_cnt  (n_issue),
    .o_head_data(head_data),
    .o_next_data(next_data),
    .o_count    (count)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) bank_sel_q <= BANK1;
    else          bank_sel_q <= bank_sel_d;
  end

  // Only a single-word issue shifts the alternation phase; pairs keep it.
  always_comb begin
    bank_sel_d = bank_sel_q;
    if (i_flush)
      bank_sel_d = BANK1;
    else if (n_issue == 2'd1)
      bank_sel_d = (bank_sel_q == BANK1) ? BANK2 : BANK1;
  end

  always_comb begin
    o_wr      = 1'b0;
    o_wr2     = 1'b0;
    o_w_data  = '0;
    o_w_data2 = '0;
    if (n_issue == 2'd1) begin
      if (bank_sel_q == BANK1) begin
        o_wr     = 1'b1;
        o_w_data = head_data;
      end else begin
        o_wr2     = 1'b1;
        o_w_data2 = head_data;
      end
    end else if (n_issue == 2'd2) begin
      o_wr      = 1'b1;
      o_wr2     = 1'b1;
      o_w_data  = (bank_sel_q == BANK1) ? head_data : next_data;
      o_w_data2 = (bank_sel_q == BANK1) ? next_data : head_data;
    end
  end

  assign o_count = count;
  assign o_busy  = (count != '0);

endmodule

// File: tb/tb_dict_update_arbiter.sv
// Directed self-checking bench for dict_update_arbiter.
module tb_dict_update_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic [3:0]  i_valid;
  logic [127:0] i_data;
  logic        o_ready;
  logic        i_hold;
  logic        i_flush;
  logic        o_wr;
  logic [31:0] o_w_data;
  logic        o_wr2;
  logic [31:0] o_w_data2;
  logic [3:0]  o_count;
  logic        o_busy;

  int unsigned vectors;
  int unsigned miscompares;

  dict_update_arbiter #(
    .DATA_WIDTH(32),
    .LANES     (4),
    .QDEPTH    (8)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_hold   (i_hold),
    .i_flush  (i_flush),
    .o_wr     (o_wr),
    .o_w_data (o_w_data),
    .o_wr2    (o_wr2),
    .o_w_data2(o_w_data2),
    .o_count  (o_count),
    .o_busy   (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic wr, input logic [31:0] d,
                         input logic wr2, input logic [31:0] d2);
    chk({tag, ".wr"},  64'(o_wr),      64'(wr));
    chk({tag, ".wd"},  64'(o_w_data),  64'(d));
    chk({tag, ".wr2"}, 64'(o_wr2),     64'(wr2));
    chk({tag, ".wd2"}, 64'(o_w_data2), 64'(d2));
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] d3);
    i_valid = v;
    i_data  = {d3, d2, d1, d0};
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    i_reset = 1'b0;
    i_hold  = 1'b0;
    i_flush = 1'b0;
    drive(4'b0000, '0, '0, '0, '0);

    // Reset state
    #2;
    chk_out("rst", 1'b0, '0, 1'b0, '0);
    chk("rst.count", 64'(o_count), 64'd0);
    chk("rst.busy",  64'(o_busy),  64'd0);
    chk("rst.ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    step();

    // Full batch of four
    drive(4'b1111, 32'hA0, 32'hB0, 32'hC0, 32'hD0);
    #1;
    chk("b4.ready", 64'(o_ready), 64'd1);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("b4.c1", 1'b1, 32'hA0, 1'b1, 32'hB0);
    chk("b4.c1.count", 64'(o_count), 64'd4);
    step();
    chk_out("b4.c2", 1'b1, 32'hC0, 1'b1, 32'hD0);
    chk("b4.c2.count", 64'(o_count), 64'd2);
    step();
    chk_out("b4.c3", 1'b0, '0, 1'b0, '0);
    chk("b4.c3.busy", 64'(o_busy), 64'd0);

    // Sparse lanes compact; single words alternate banks
    drive(4'b0101, 32'hA1, 32'hDEAD, 32'hC1, 32'hBEEF);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("sp", 1'b1, 32'hA1, 1'b1, 32'hC1);
    step();
    drive(4'b0001, 32'hE1, '0, '0, '0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("sgE", 1'b1, 32'hE1, 1'b0, '0);
    step();
    drive(4'b0001, 32'hF1, '0, '0, '0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("sgF", 1'b0, '0, 1'b1, 32'hF1);
    step();

    // Hold across a batch: X then Y0..Y3
    drive(4'b0001, 32'h58, '0, '0, '0);
    step();
    i_hold = 1'b1;
    drive(4'b1111, 32'h10, 32'h11, 32'h12, 32'h13);
    #1;
    chk_out("hd1", 1'b0, '0, 1'b0, '0);
    chk("hd1.count", 64'(o_count), 64'd1);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("hd2", 1'b0, '0, 1'b0, '0);
    chk("hd2.count", 64'(o_count), 64'd5);
    step();
    chk_out("hd3", 1'b0, '0, 1'b0, '0);
    chk("hd3.count", 64'(o_count), 64'd5);
    step();
    i_hold = 1'b0;
    #1;
    chk_out("rl1", 1'b1, 32'h58, 1'b1, 32'h10);
    step();
    chk_out("rl2", 1'b1, 32'h11, 1'b1, 32'h12);
    chk("rl2.count", 64'(o_count), 64'd3);
    step();
    chk_out("rl3", 1'b1, 32'h13, 1'b0, '0);
    chk("rl3.count", 64'(o_count), 64'd1);
    step();
    chk("rl4.count", 64'(o_count), 64'd0);

    // Fill to full under hold; phase now starts on bank 2
    i_hold = 1'b1;
    drive(4'b1111, 32'h20, 32'h21, 32'h22, 32'h23);
    step();
    drive(4'b1111, 32'h30, 32'h31, 32'h32, 32'h33);
    step();
    drive(4'b1111, 32'h40, 32'h41, 32'h42, 32'h43);
    #1;
    chk("full.count", 64'(o_count), 64'd8);
    chk("full.ready", 64'(o_ready), 64'd0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk("full.ign", 64'(o_count), 64'd8);
    i_hold = 1'b0;
    #1;
    chk_out("dr1", 1'b1, 32'h21, 1'b1, 32'h20);
    step();
    chk_out("dr2", 1'b1, 32'h23, 1'b1, 32'h22);
    chk("dr2.count", 64'(o_count), 64'd6);
    chk("dr2.ready", 64'(o_ready), 64'd0);
    step();
    chk_out("dr3", 1'b1, 32'h31, 1'b1, 32'h30);
    chk("dr3.count", 64'(o_count), 64'd4);
    chk("dr3.ready", 64'(o_ready), 64'd1);
    step();
    step();
    chk("dr5.count", 64'(o_count), 64'd0);

    // Flush from count 6 with bank phase on bank 2
    drive(4'b0001, 32'h50, '0, '0, '0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("fz", 1'b0, '0, 1'b1, 32'h50);
    step();
    drive(4'b0001, 32'h51, '0, '0, '0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("fz2", 1'b1, 32'h51, 1'b0, '0);
    step();
    i_hold = 1'b1;
    drive(4'b1111, 32'h60, 32'h61, 32'h62, 32'h63);
    step();
    drive(4'b0011, 32'h64, 32'h65, '0, '0);
    step();
    drive(4'b1111, 32'h70, 32'h71, 32'h72, 32'h73);
    i_hold  = 1'b0;
    i_flush = 1'b1;
    #1;
    chk("fl.count", 64'(o_count), 64'd6);
    chk("fl.ready", 64'(o_ready), 64'd0);
    chk_out("fl", 1'b0, '0, 1'b0, '0);
    step();
    i_flush = 1'b0;
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk("fl2.count", 64'(o_count), 64'd0);
    chk_out("fl2", 1'b0, '0, 1'b0, '0);
    drive(4'b0001, 32'h80, '0, '0, '0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("flw", 1'b1, 32'h80, 1'b0, '0);
    step();

    // Asynchronous reset mid-drain at count 5
    i_hold = 1'b1;
    drive(4'b1111, 32'h90, 32'h91, 32'h92, 32'h93);
    step();
    drive(4'b0111, 32'h94, 32'h95, 32'h96, '0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    i_hold = 1'b0;
    #1;
    chk_out("ar0", 1'b1, 32'h91, 1'b1, 32'h90);
    step();
    chk("ar1.count", 64'(o_count), 64'd5);
    #2;
    i_reset = 1'b0;
    #1;
    chk_out("ar", 1'b0, '0, 1'b0, '0);
    chk("ar.count", 64'(o_count), 64'd0);
    chk("ar.ready", 64'(o_ready), 64'd1);
    chk("ar.busy",  64'(o_busy),  64'd0);
    #2;
    i_reset = 1'b1;
    step();
    drive(4'b0001, 32'hA5, '0, '0, '0);
    step();
    drive(4'b0000, '0, '0, '0, '0);
    #1;
    chk_out("ar.w", 1'b1, 32'hA5, 1'b0, '0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
